param_fifo: RTL and testbench

//  Parametrised single-clock FIFO; next generation of our FIFO with full/empty checker.

---
 rtl/param_fifo_pkg.sv | 21 ++
 rtl/param_fifo_mem.sv | 26 ++
 rtl/param_fifo.sv | 135 +++++++++++++
 tb/tb_param_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/param_fifo_pkg.sv
// Shared helpers for the parametrised FIFO:
// pointer wrap and counter width sizing.
package param_fifo_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Depth need not be a power of two, so wrap explicitly.
  function automatic int unsigned ptr_inc(
    input int unsigned ptr,
    input int unsigned depth
  );
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// FIFO storage: DEPTH x WIDTH array,
// one synchronous write port, one asynchronous read port.
module param_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags,
// sticky overflow/underflow and standard or FWFT read mode.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  input  logic                      clr_err,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             af_q, ae_q;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] head;

  // Acceptance looks only at registered flags,
  // so a full FIFO still drains and an empty one still fills.
  always_comb begin
    wr_acc   = wr_en && !full_q;
    rd_acc   = rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
    end
    if (rd_acc) begin
      rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end
    ovf_d = clr_err ? 1'b0 : (ovf_q || (wr_en && full_q));
    udf_d = clr_err ? 1'b0 : (udf_q || (rd_en && empty_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= CW'(AF_THRESH));
      ae_q     <= (count_d <= CW'(AE_THRESH));
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  param_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word is shown directly; zero while empty so
    // uninitialised storage never leaks out.
    assign rd_data  = empty_q ? '0 : head;
    assign rd_valid = !empty_q;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) begin
          rd_data_q <= head;
        end
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench: vector table on a 16-deep standard FIFO,
// a 5-deep wrap stream and a 4-deep FWFT instance.
module tb_param_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 16-deep, standard read
  logic       rst_a, wr_a, rd_a, clr_a;
  logic [7:0] wd_a, rdd_a;
  logic       rv_a, full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
  logic [4:0] cnt_a;

  // 5-deep, standard read
  logic       rst_b, wr_b, rd_b, clr_b;
  logic [7:0] wd_b, rdd_b;
  logic       rv_b, full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
  logic [2:0] cnt_b;

  // 4-deep, first-word-fall-through
  logic       rst_c, wr_c, rd_c, clr_c;
  logic [7:0] wd_c, rdd_c;
  logic       rv_c, full_c, empty_c, af_c, ae_c, ovf_c, udf_c;
  logic [2:0] cnt_c;

  param_fifo #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14),
               .AE_THRESH(2), .FWFT(0)) u_a (
    .clk(clk), .rst(rst_a), .wr_en(wr_a), .wr_data(wd_a),
    .rd_en(rd_a), .rd_data(rdd_a), .rd_valid(rv_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a),
    .almost_empty(ae_a), .count(cnt_a), .clr_err(clr_a),
    .overflow(ovf_a), .underflow(udf_a)
  );

  param_fifo #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4),
               .AE_THRESH(1), .FWFT(0)) u_b (
    .clk(clk), .rst(rst_b), .wr_en(wr_b), .wr_data(wd_b),
    .rd_en(rd_b), .rd_data(rdd_b), .rd_valid(rv_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .count(cnt_b), .clr_err(clr_b),
    .overflow(ovf_b), .underflow(udf_b)
  );

  param_fifo #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3),
               .AE_THRESH(1), .FWFT(1)) u_c (
    .clk(clk), .rst(rst_c), .wr_en(wr_c), .wr_data(wd_c),
    .rd_en(rd_c), .rd_data(rdd_c), .rd_valid(rv_c),
    .full(full_c), .empty(empty_c), .almost_full(af_c),
    .almost_empty(ae_c), .count(cnt_c), .clr_err(clr_c),
    .overflow(ovf_c), .underflow(udf_c)
  );

  typedef struct {
    logic       wr, rd, clr;
    logic [7:0] wd;
    logic [4:0] cnt;
    logic       full, empty, af, ae, ovf, udf, rv;
    logic [7:0] rdata;
    logic       chk_rd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input int wr, rd, clr, wd, cnt, full, empty,
    input int af, ae, ovf, udf, rv, rdata, chk_rd
  );
    vec_t v;
    v.wr = wr[0];  v.rd = rd[0];  v.clr = clr[0];
    v.wd = wd[7:0]; v.cnt = cnt[4:0];
    v.full = full[0]; v.empty = empty[0];
    v.af = af[0]; v.ae = ae[0];
    v.ovf = ovf[0]; v.udf = udf[0]; v.rv = rv[0];
    v.rdata = rdata[7:0]; v.chk_rd = chk_rd[0];
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_c(input logic w, input logic r,
                        input logic [7:0] d);
    wr_c = w; rd_c = r; wd_c = d;
    @(posedge clk); #1;
    wr_c = 1'b0; rd_c = 1'b0;
  endtask

  int         mcnt, sent, got;
  logic       wacc, racc;
  logic [7:0] pend_d;
  logic [7:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    {wr_a, rd_a, clr_a, wd_a} = '0;
    {wr_b, rd_b, clr_b, wd_b} = '0;
    {wr_c, rd_c, clr_c, wd_c} = '0;

    // Table for the 16-deep instance
    for (int i = 0; i < 16; i++)
      vt.push_back(mk(1, 0, 0, i, i + 1, int'(i == 15), 0,
                      int'(i + 1 >= 14), int'(i + 1 <= 2),
                      0, 0, 0, 0, 1));
    vt.push_back(mk(1, 0, 0, 'hFF, 16, 1, 0, 1, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 1, 0, 16, 1, 0, 1, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(1, 1, 0, 'hEE, 15, 0, 0, 1, 0, 1, 0, 1, 0, 1));
    vt.push_back(mk(0, 0, 1, 0, 15, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    for (int i = 1; i < 16; i++)
      vt.push_back(mk(0, 1, 0, 0, 15 - i, 0, int'(i == 15),
                      int'(15 - i >= 14), int'(15 - i <= 2),
                      0, 0, 1, i, 1));
    vt.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 'h0F, 1));
    vt.push_back(mk(1, 1, 0, 'h33, 1, 0, 0, 0, 1, 0, 1, 0, 'h0F, 1));
    vt.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 'h33, 1));
    vt.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 'h33, 1));

    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #1;

    chk("rst.count", 32'(cnt_a), 0);
    chk("rst.empty", 32'(empty_a), 1);
    chk("rst.full", 32'(full_a), 0);
    chk("rst.ae", 32'(ae_a), 1);
    chk("rst.af", 32'(af_a), 0);
    chk("rst.rv", 32'(rv_a), 0);
    chk("rst.rdata", 32'(rdd_a), 0);
    chk("rst.ovf", 32'(ovf_a), 0);
    chk("rst.udf", 32'(udf_a), 0);

    foreach (vt[k]) begin
      wr_a = vt[k].wr; rd_a = vt[k].rd;
      clr_a = vt[k].clr; wd_a = vt[k].wd;
      @(posedge clk); #1;
      chk($sformatf("a[%0d].count", k), 32'(cnt_a), 32'(vt[k].cnt));
      chk($sformatf("a[%0d].full", k), 32'(full_a), 32'(vt[k].full));
      chk($sformatf("a[%0d].empty", k), 32'(empty_a), 32'(vt[k].empty));
      chk($sformatf("a[%0d].af", k), 32'(af_a), 32'(vt[k].af));
      chk($sformatf("a[%0d].ae", k), 32'(ae_a), 32'(vt[k].ae));
      chk($sformatf("a[%0d].ovf", k), 32'(ovf_a), 32'(vt[k].ovf));
      chk($sformatf("a[%0d].udf", k), 32'(udf_a), 32'(vt[k].udf));
      chk($sformatf("a[%0d].rv", k), 32'(rv_a), 32'(vt[k].rv));
      if (vt[k].chk_rd)
        chk($sformatf("a[%0d].rdata", k), 32'(rdd_a), 32'(vt[k].rdata));
    end
    {wr_a, rd_a, clr_a} = '0;

    // Depth-5 stream with random gaps across several wraps
    mcnt = 0; sent = 0; got = 0;
    for (int cyc = 0; cyc < 2000 && got < 20; cyc++) begin
      wr_b = (sent < 20) && ($urandom_range(0, 2) != 0);
      rd_b = ($urandom_range(0, 2) != 0);
      wd_b = 8'(8'h40 + sent);
      wacc = wr_b && (mcnt < 5);
      racc = rd_b && (mcnt > 0);
      if (racc) pend_d = exp_q.pop_front();
      if (wacc) begin
        exp_q.push_back(wd_b);
        sent++;
      end
      mcnt = mcnt + int'(wacc) - int'(racc);
      @(posedge clk); #1;
      chk("b.count", 32'(cnt_b), 32'(mcnt));
      chk("b.full", 32'(full_b), 32'(mcnt == 5));
      chk("b.empty", 32'(empty_b), 32'(mcnt == 0));
      chk("b.rv", 32'(rv_b), 32'(racc));
      if (racc) begin
        chk($sformatf("b.rdata#%0d", got), 32'(rdd_b), 32'(pend_d));
        got++;
      end
    end
    {wr_b, rd_b} = '0;
    chk("b.received", 32'(got), 20);

    // FWFT instance
    chk("c.rst.empty", 32'(empty_c), 1);
    chk("c.rst.rv", 32'(rv_c), 0);
    chk("c.rst.rdata", 32'(rdd_c), 0);
    step_c(1'b1, 1'b0, 8'hA5);
    chk("c.first.rv", 32'(rv_c), 1);
    chk("c.first.rdata", 32'(rdd_c), 32'h A5);
    chk("c.first.count", 32'(cnt_c), 1);
    step_c(1'b1, 1'b0, 8'h5A);
    chk("c.hold.rdata", 32'(rdd_c), 32'h A5);
    step_c(1'b0, 1'b1, 8'h00);
    chk("c.pop.rdata", 32'(rdd_c), 32'h 5A);
    chk("c.pop.count", 32'(cnt_c), 1);
    step_c(1'b1, 1'b0, 8'h11);
    step_c(1'b1, 1'b0, 8'h22);
    chk("c.af", 32'(af_c), 1);
    step_c(1'b1, 1'b0, 8'h33);
    chk("c.full", 32'(full_c), 1);
    step_c(1'b1, 1'b0, 8'h44);
    chk("c.ovf", 32'(ovf_c), 1);
    chk("c.ovf.count", 32'(cnt_c), 4);

    // Asynchronous reset mid-cycle, checked before any edge
    #3 rst_c = 1'b1;
    #1;
    chk("c.arst.empty", 32'(empty_c), 1);
    chk("c.arst.full", 32'(full_c), 0);
    chk("c.arst.count", 32'(cnt_c), 0);
    chk("c.arst.ovf", 32'(ovf_c), 0);
    chk("c.arst.rv", 32'(rv_c), 0);
    @(negedge clk);
    rst_c = 1'b0;
    @(posedge clk); #1;
    step_c(1'b1, 1'b0, 8'h77);
    chk("c.after.rdata", 32'(rdd_c), 32'h77);
    chk("c.after.count", 32'(cnt_c), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
